jk_register_bank: RTL and testbench
===================================

JK_REGISTER_BANK -- requirements
Module: jk_register_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits in the bank (1..32).
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Parameter CNT_W, default 8, width of the change counter (2..16).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port en  input  1  bank enable for J/K-driven updates.
REQ-007 Port mode  input  2  00=JK, 01=D, 10=T, 11=SR.
REQ-008 Port j  input  WIDTH  per-bit J / D / T / S input.
REQ-009 Port k  input  WIDTH  per-bit K / R input; ignored in D and T modes.
REQ-010 Port set  input  WIDTH  per-bit synchronous preset.
REQ-011 Port clr  input  WIDTH  per-bit synchronous clear.
REQ-012 Port cnt_clr  input  1  synchronous clear of chg_cnt.
REQ-013 Port err_clr  input  1  synchronous clear of sr_err.
REQ-014 Port q  output  WIDTH  registered bank state.
REQ-015 Port q_n  output  WIDTH  bitwise complement of q.
REQ-016 Port changed  output  1  registered pulse: q changed at previous edge.
REQ-017 Port chg_cnt  output  CNT_W  saturating count of edges at which q changed.
REQ-018 Port sr_err  output  1  sticky flag: forbidden S=R=1 seen in SR mode.

Function
REQ-019 Per-bit next-state priority SHALL be: rst > clr > set > (en and mode rule) > hold.
REQ-020 clr[i] and set[i] both 1 SHALL clear bit i; set/clr SHALL act regardless of en.
REQ-021 JK mode: j=0,k=0 hold; j=0,k=1 -> 0; j=1,k=0 -> 1; j=1,k=1 -> toggle.
REQ-022 D mode: bit i SHALL load j[i].
REQ-023 T mode: j[i]=1 toggles bit i; j[i]=0 holds.
REQ-024 SR mode: j=S, k=R; S only -> 1, R only -> 0, neither -> hold; S=R=1 -> bit holds.
REQ-025 en=0 SHALL hold every bit not addressed by set/clr; mode/j/k ignored.
REQ-026 q SHALL update one edge after inputs are sampled (latency 1); q_n SHALL equal ~q combinationally, never X after reset.
REQ-027 sr_err SHALL set at an edge where en=1, mode=11 and (j & k & ~set & ~clr) is nonzero; it SHALL stay 1 until err_clr or rst.
REQ-028 err_clr coinciding with a new SR violation SHALL leave sr_err=1 (set wins).
REQ-029 changed SHALL be 1 for exactly the cycle following each edge at which q's new value differs from its old value, else 0.
REQ-030 chg_cnt SHALL increment by 1 on each edge at which q changes, saturating at 2^CNT_W-1 without wrap.
REQ-031 cnt_clr SHALL force chg_cnt to 0 at that edge, winning over a simultaneous increment.
REQ-032 mode changes SHALL take effect at the same edge they are sampled; no pipeline of mode.

Reset
REQ-033 rst=1 SHALL immediately, without clk, force q=RESET_VALUE, q_n=~RESET_VALUE, changed=0, chg_cnt=0, sr_err=0.
REQ-034 While rst=1, all synchronous inputs SHALL be ignored; first update occurs at the first rising edge after rst falls.
REQ-035 Assertion of rst mid-operation SHALL abort any pending update; the reset load SHALL NOT count as a change nor pulse changed.

Verification
REQ-036 WIDTH=8, reset, mode=00, en=1, j=0xFF,k=0xFF for 3 edges -> q=0xFF,0x00,0xFF; changed=1 each following cycle; chg_cnt=3.
REQ-037 mode=01, j=0xA5, en=0 -> q holds; then en=1 -> q=0xA5 one edge later; set=0x01,clr=0x01 same edge -> bit0=0.
REQ-038 mode=11, en=1, j=0x0C,k=0x04 -> bit2 holds, bit3=1, sr_err=1; err_clr=1 with j=k=0 -> sr_err=0; err_clr with j=k=0x01 -> sr_err stays 1.
REQ-039 CNT_W=2, toggle 5 edges -> chg_cnt=3 (saturated); cnt_clr with concurrent toggle -> chg_cnt=0.
REQ-040 RESET_VALUE=0x3C, assert rst between clk edges mid-toggle run -> q=0x3C immediately, chg_cnt=0, changed=0; no pulse after release until a real change.

Source files
------------

// File: rtl/jk_register_bank.sv
// jk_register_bank
// ----------------
// A bank of WIDTH flip-flops, each behaving as a JK, D, T or SR flip-flop
// depending on the shared 2-bit mode input. Per-bit synchronous set/clear
// override the mode logic and act even when the bank is disabled. Alongside
// the state the block reports a one-cycle "changed" pulse, a saturating count
// of edges at which the state changed, and a sticky flag for forbidden S=R=1
// requests seen in SR mode.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   en       : enables the mode-driven update (set/clr work regardless)
//   mode     : 00=JK, 01=D, 10=T, 11=SR
//   j        : per-bit J / D / T / S input
//   k        : per-bit K / R input (ignored in D and T modes)
//   set      : per-bit synchronous preset
//   clr      : per-bit synchronous clear (wins over set)
//   cnt_clr  : synchronous clear of chg_cnt
//   err_clr  : synchronous clear of sr_err
//   q        : registered bank state
//   q_n      : bitwise complement of q
//   changed  : registered pulse, high for the cycle after q changed
//   chg_cnt  : saturating count of edges at which q changed
//   sr_err   : sticky flag for S=R=1 seen in SR mode

module jk_register_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             changed,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             sr_err
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             sr_err_q, sr_err_d;

  logic [WIDTH-1:0] mode_next;
  logic [WIDTH-1:0] en_next;
  logic             sr_viol;
  logic             cnt_sat;

  // Mode-driven next state for every bit, written as characteristic
  // equations so the whole bank is evaluated as one vector. The JK form is
  // Q+ = J&~Q | ~K&Q. The SR form sets on S-only, clears on R-only and holds
  // when S and R are both high, so a forbidden request never disturbs the bit.
  always_comb begin
    mode_next = q_q;
    case (mode_e'(mode))
      MODE_JK: mode_next = (j & ~q_q) | (~k & q_q);
      MODE_D:  mode_next = j;
      MODE_T:  mode_next = q_q ^ j;
      MODE_SR: mode_next = (j & ~k) | (q_q & ~(k & ~j));
      default: mode_next = q_q;
    endcase
  end

  // Final per-bit next state: clear beats set, set beats the mode rule, and
  // the mode rule only applies while the bank is enabled. The changed pulse
  // and counter increment are derived from the very same next-state value, so
  // a set/clr that rewrites a bit to its existing value is not a change.
  always_comb begin
    en_next   = en ? mode_next : q_q;
    q_d       = (en_next | set) & ~clr;
    changed_d = (q_d != q_q);
  end

  // Change counter: cnt_clr has priority over an increment and the count
  // sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_sat   = &chg_cnt_q;
    chg_cnt_d = chg_cnt_q;
    if (cnt_clr) begin
      chg_cnt_d = '0;
    end else if (changed_d && !cnt_sat) begin
      chg_cnt_d = chg_cnt_q + CNT_W'(1);
    end
  end

  // SR violation detection. Bits that set/clr are overriding this edge do not
  // count, because the forbidden request has no effect on them. A new
  // violation wins over a simultaneous err_clr.
  always_comb begin
    sr_viol  = en && (mode_e'(mode) == MODE_SR) && (|(j & k & ~set & ~clr));
    sr_err_d = sr_err_q;
    if (sr_viol) begin
      sr_err_d = 1'b1;
    end else if (err_clr) begin
      sr_err_d = 1'b0;
    end
  end

  // All state lives here. The asynchronous reset loads the reset value and
  // clears the status outputs without any clock, and because the reset load
  // happens outside the clocked path it is never seen as a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= RESET_VALUE;
      changed_q <= 1'b0;
      chg_cnt_q <= '0;
      sr_err_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      chg_cnt_q <= chg_cnt_d;
      sr_err_q  <= sr_err_d;
    end
  end

  assign q       = q_q;
  assign q_n     = ~q_q;
  assign changed = changed_q;
  assign chg_cnt = chg_cnt_q;
  assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank
// -------------------
// Directed bench for jk_register_bank. Instance dut_a uses the default
// parameters and is driven from a table of hand-computed vectors. Instance
// dut_b uses RESET_VALUE=0x3C and CNT_W=2 and is driven by hand-written
// sequences for counter saturation, cnt_clr priority and a mid-cycle reset.
// Both instances share their synchronous inputs but have separate resets.

module tb_jk_register_bank;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] set;
  logic [7:0] clr;
  logic       cnt_clr;
  logic       err_clr;

  logic [7:0] q_a, q_n_a;
  logic       changed_a, sr_err_a;
  logic [7:0] chg_cnt_a;

  logic [7:0] q_b, q_n_b;
  logic       changed_b, sr_err_b;
  logic [1:0] chg_cnt_b;

  int n_vectors;
  int n_miscompares;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] set;
    logic [7:0] clr;
    logic       cnt_clr;
    logic       err_clr;
    logic [7:0] exp_q;
    logic       exp_changed;
    int         exp_cnt;
    logic       exp_err;
  } vec_t;

  localparam int NUM_VECS = 19;
  vec_t vecs [NUM_VECS];

  jk_register_bank #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00),
    .CNT_W      (8)
  ) dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .en     (en),
    .mode   (mode),
    .j      (j),
    .k      (k),
    .set    (set),
    .clr    (clr),
    .cnt_clr(cnt_clr),
    .err_clr(err_clr),
    .q      (q_a),
    .q_n    (q_n_a),
    .changed(changed_a),
    .chg_cnt(chg_cnt_a),
    .sr_err (sr_err_a)
  );

  jk_register_bank #(
    .WIDTH      (8),
    .RESET_VALUE(8'h3C),
    .CNT_W      (2)
  ) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .en     (en),
    .mode   (mode),
    .j      (j),
    .k      (k),
    .set    (set),
    .clr    (clr),
    .cnt_clr(cnt_clr),
    .err_clr(err_clr),
    .q      (q_b),
    .q_n    (q_n_b),
    .changed(changed_b),
    .chg_cnt(chg_cnt_b),
    .sr_err (sr_err_b)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic en_v, input logic [1:0] mode_v,
                              input logic [7:0] j_v, input logic [7:0] k_v,
                              input logic [7:0] set_v, input logic [7:0] clr_v,
                              input logic cc_v, input logic ec_v,
                              input logic [7:0] eq, input logic ech,
                              input int ecnt, input logic eerr);
    vec_t v;
    v.en = en_v; v.mode = mode_v; v.j = j_v; v.k = k_v;
    v.set = set_v; v.clr = clr_v; v.cnt_clr = cc_v; v.err_clr = ec_v;
    v.exp_q = eq; v.exp_changed = ech; v.exp_cnt = ecnt; v.exp_err = eerr;
    return v;
  endfunction

  // Drive all synchronous inputs on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic en_v, input logic [1:0] mode_v,
                               input logic [7:0] j_v, input logic [7:0] k_v,
                               input logic [7:0] set_v, input logic [7:0] clr_v,
                               input logic cc_v, input logic ec_v);
    @(negedge clk);
    en = en_v; mode = mode_v; j = j_v; k = k_v;
    set = set_v; clr = clr_v; cnt_clr = cc_v; err_clr = ec_v;
  endtask

  // Compare one observation of a DUT against the required values.
  task automatic checkOutput(input string name,
                             input logic [7:0] act_q, input logic [7:0] act_qn,
                             input logic act_ch, input int act_cnt, input logic act_err,
                             input logic [7:0] exp_q, input logic exp_ch,
                             input int exp_cnt, input logic exp_err);
    n_vectors++;
    if (act_q !== exp_q || act_qn !== ~exp_q || act_ch !== exp_ch ||
        act_cnt != exp_cnt || act_err !== exp_err) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got q=%h q_n=%h changed=%b chg_cnt=%0d sr_err=%b, required q=%h q_n=%h changed=%b chg_cnt=%0d sr_err=%b",
               name, act_q, act_qn, act_ch, act_cnt, act_err,
               exp_q, ~exp_q, exp_ch, exp_cnt, exp_err);
    end
  endtask

  task automatic checkA(input string name, input logic [7:0] eq, input logic ech,
                        input int ecnt, input logic eerr);
    checkOutput(name, q_a, q_n_a, changed_a, int'(chg_cnt_a), sr_err_a, eq, ech, ecnt, eerr);
  endtask

  task automatic checkB(input string name, input logic [7:0] eq, input logic ech,
                        input int ecnt);
    checkOutput(name, q_b, q_n_b, changed_b, int'(chg_cnt_b), sr_err_b, eq, ech, ecnt, 1'b0);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    en = 1'b0; mode = 2'b00; j = '0; k = '0; set = '0; clr = '0;
    cnt_clr = 1'b0; err_clr = 1'b0;

    //            en mode   j      k      set    clr   cc ec  q     ch cnt err
    vecs[0]  = mk(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 1,  0);
    vecs[1]  = mk(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 1, 2,  0);
    vecs[2]  = mk(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 3,  0);
    vecs[3]  = mk(1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 3,  0);
    vecs[4]  = mk(1, 2'b00, 8'h0F, 8'hF0, 8'h00, 8'h00, 0, 0, 8'h0F, 1, 4,  0);
    vecs[5]  = mk(1, 2'b00, 8'h33, 8'h55, 8'h00, 8'h00, 0, 0, 8'h3A, 1, 5,  0);
    vecs[6]  = mk(0, 2'b01, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 8'h3A, 0, 5,  0);
    vecs[7]  = mk(1, 2'b01, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5, 1, 6,  0);
    vecs[8]  = mk(1, 2'b01, 8'hA5, 8'h00, 8'h01, 8'h01, 0, 0, 8'hA4, 1, 7,  0);
    vecs[9]  = mk(1, 2'b10, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 0, 8'hAB, 1, 8,  0);
    vecs[10] = mk(1, 2'b10, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, 8'hAB, 0, 8,  0);
    vecs[11] = mk(1, 2'b11, 8'h0C, 8'h05, 8'h00, 8'h00, 0, 0, 8'hAA, 1, 9,  1);
    vecs[12] = mk(1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'hAA, 0, 9,  0);
    vecs[13] = mk(1, 2'b11, 8'h01, 8'h01, 8'h00, 8'h00, 0, 1, 8'hAA, 0, 9,  1);
    vecs[14] = mk(1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'hAA, 0, 9,  0);
    vecs[15] = mk(0, 2'b11, 8'hFF, 8'hFF, 8'h0F, 8'h30, 0, 0, 8'h8F, 1, 10, 0);
    vecs[16] = mk(1, 2'b11, 8'hF0, 8'hF0, 8'hF0, 8'h00, 0, 0, 8'hFF, 1, 11, 0);
    vecs[17] = mk(1, 2'b10, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0, 8'hFE, 1, 0,  0);
    vecs[18] = mk(1, 2'b10, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 8'h7E, 1, 1,  0);

    // Reset state of dut_a, seen before any clock edge.
    #2;
    checkA("reset_a", 8'h00, 1'b0, 0, 1'b0);

    @(negedge clk);
    rst_a = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k,
                    vecs[i].set, vecs[i].clr, vecs[i].cnt_clr, vecs[i].err_clr);
      @(posedge clk);
      #1;
      checkA($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_changed,
             vecs[i].exp_cnt, vecs[i].exp_err);
    end

    // Second phase: dut_b sequences, dut_a parked in reset.
    applyStimulus(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    rst_a = 1'b1;
    rst_b = 1'b0;
    #1;
    checkB("reset_b", 8'h3C, 1'b0, 0);

    // Five toggles of every bit: the 2-bit counter saturates at 3.
    applyStimulus(1, 2'b10, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
    @(posedge clk); #1; checkB("sat_t1", 8'hC3, 1'b1, 1);
    @(posedge clk); #1; checkB("sat_t2", 8'h3C, 1'b1, 2);
    @(posedge clk); #1; checkB("sat_t3", 8'hC3, 1'b1, 3);
    @(posedge clk); #1; checkB("sat_t4", 8'h3C, 1'b1, 3);
    @(posedge clk); #1; checkB("sat_t5", 8'hC3, 1'b1, 3);

    // cnt_clr wins over the increment from a concurrent toggle.
    applyStimulus(1, 2'b10, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0);
    @(posedge clk); #1; checkB("cnt_clr_toggle", 8'h3C, 1'b1, 0);

    applyStimulus(1, 2'b10, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
    @(posedge clk); #1; checkB("toggle_after_clr", 8'hC3, 1'b1, 1);

    // Reset asserted while clk is high, between edges, mid-toggle run.
    #2;
    rst_b = 1'b1;
    #1;
    checkB("async_reset", 8'h3C, 1'b0, 0);

    // Inputs still request toggles while reset is held: ignored.
    @(posedge clk); #1; checkB("held_in_reset", 8'h3C, 1'b0, 0);

    // Release with the bank idle: no spurious pulse.
    applyStimulus(0, 2'b10, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0);
    rst_b = 1'b0;
    @(posedge clk); #1; checkB("idle_after_release", 8'h3C, 1'b0, 0);

    // First real change after release.
    applyStimulus(1, 2'b10, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
    @(posedge clk); #1; checkB("first_change", 8'h3D, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
